execute_stage: RTL and testbench
================================

# execute_stage

EX stage of the five-stage RV32IM pipeline, holding the ID/EX→EX/MEM boundary. It computes ALU results, branch conditions, PC+imm and jalr targets, and registers them, with all control bypass signals, into the EX/MEM register consumed by the memory stage. It contains an iterative multiply/divide unit and stalls upstream while that unit is busy. It accepts a flush from branch resolution in MEM.

## Interface
Parameters:
- `XLEN`, 32, datapath width
- `MD_CYCLES`, 32, multiply/divide iteration count

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `flush_in`  in  1  kill the current EX instruction (wrong path)
- `Ctl_ALUSrc_in`  in  1  operand B select: 1 = `Imm_in`, 0 = `ReadData2_in`
- `alu_op_in`  in  5  operation code from the shared package
- `funct3_in`  in  3  branch type
- `Ctl_MemtoReg_in`, `Ctl_RegWrite_in`, `Ctl_MemRead_in`, `Ctl_MemWrite_in`, `Ctl_Branch_in`, `jal_in`, `jalr_in`  in  1 each  control bypass
- `Rd_in`  in  5  destination register
- `PC_in`, `Imm_in`, `ReadData1_in`, `ReadData2_in`  in  32 each  operands
- `Ctl_MemtoReg_out`, `Ctl_RegWrite_out`, `Ctl_MemRead_out`, `Ctl_MemWrite_out`, `Ctl_Branch_out`, `jal_out`, `jalr_out`  out  1 each  registered control
- `Rd_out`  out  5  registered destination register
- `Zero_out`  out  1  registered branch-condition-true
- `ALUresult_out`, `Write_Data_out`, `PCimm_out`, `PC_out`  out  32 each  registered result, rs2 for stores, PC+imm, PC
- `stall_out`  out  1  combinational; upstream must hold ID/EX while high

## Operation
Operand and result rules:
- B = `Ctl_ALUSrc_in` ? `Imm_in` : `ReadData2_in`.
- ALU ops: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASSB. Shift amount is B[4:0].
- For `jalr_in`, ALUresult = (rs1 + imm) & ~1. The memory stage forwards it as the jump target.
- PCimm = `PC_in` + `Imm_in`, modulo 2^32.
- `Zero_out` per `funct3_in`:
  - 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU.
  - Other codes give 0.
  - The branch compare always uses rs1 vs `ReadData2_in`, never `Imm_in`.

Multiply/divide:
- Ops: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU. They run in sub-module `muldiv_unit`.
- Multiplies use shift-add on magnitudes with sign fix-up. Divides use restoring division on magnitudes.
- Divide by zero: quotient = 0xFFFFFFFF, remainder = dividend.
- Overflow (0x80000000 / -1): quotient = 0x80000000, remainder = 0.

FSM in `muldiv_unit`:
- IDLE → BUSY when a muldiv op is present and `flush_in` = 0. Operands load and the counter clears.
- BUSY: one iteration per cycle. After `MD_CYCLES` iterations → DONE.
- DONE: result valid. Next edge → IDLE.
- `stall_out` = (IDLE ∧ muldiv op ∧ ¬`flush_in`) ∨ BUSY.

EX/MEM register:
- On each edge with `stall_out` = 0: latch the ALU result, or the muldiv result in DONE, plus all bypass fields.
- While `stall_out` = 1: write a bubble. All seven control outs become 0; data fields are don't-care but are driven 0.

## Timing
- Reset: all outputs 0, FSM IDLE, counter 0.
- Reset mid-BUSY aborts the operation with no result.
- Single-cycle ops: inputs in cycle N → outputs valid after edge N+1.
- Muldiv op presented in cycle N:
  - `stall_out` is high in cycles N..N+`MD_CYCLES` (33 cycles).
  - DONE occurs in cycle N+`MD_CYCLES`+1.
  - The result appears on `ALUresult_out` after edge N+`MD_CYCLES`+2.
  - Total latency is `MD_CYCLES`+2 edges.
- `flush_in` has priority over everything except reset:
  - The next EX/MEM write is a bubble.
  - The FSM returns to IDLE from any state and `stall_out` drops the same cycle.
- Inputs arriving during DONE are the held instruction. DONE never re-launches an operation.

## Structure
- Shared package `riscv_pkg`:
  - `alu_op_t` (5-bit encodings for all 19 ops).
  - Branch `funct3` constants.
  - The divide-by-zero and overflow result constants.
- One sub-module, `muldiv_unit`: FSM, counter, accumulator/remainder registers, and the signed fix-up.
- The ALU, branch compare, and EX/MEM register stay in `execute_stage`.

## Test plan
- ADD, ALUSrc=1, rs1=5, imm=−3, Rd=7, RegWrite=1 → after one edge: ALUresult_out=2, Rd_out=7, Ctl_RegWrite_out=1, stall_out never high.
- BLT, funct3=100, rs1=0xFFFFFFFF, rs2=1, PC=0x40, imm=0x10 → Zero_out=1, PCimm_out=0x50. Repeat with BLTU → Zero_out=0.
- jalr, rs1=0x103, imm=4 → ALUresult_out=0x106, jalr_out=1.
- MUL 7×(−6) → stall_out high for 33 cycles, with bubbles in EX/MEM (all control outs 0) during the stall. Then ALUresult_out=0xFFFFFFD6 after edge 34. Repeat with MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- DIV 0x80000000/−1 → 0x80000000; REM 17/0 → 17; DIVU 100/7 → 14; REMU 100/7 → 2.
- Flush and reset:
  - Start DIV, assert `flush_in` in the 10th BUSY cycle → stall_out low the same cycle, FSM IDLE, next EX/MEM is a bubble. A following ADD completes normally.
  - Assert reset mid-BUSY → all outputs 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the RV32IM pipeline execute stage:
//   - alu_op_t    : 5-bit operation codes (11 integer ALU ops + 8 M-extension)
//   - F3_*        : branch funct3 encodings
//   - DIV_*       : architecturally defined divide corner-case results
//   - is_muldiv() : true when an op code belongs to the multiply/divide unit
// ----------------------------------------------------------------------------
package riscv_pkg;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SLT    = 5'd3,
        ALU_SLTU   = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_OR     = 5'd8,
        ALU_AND    = 5'd9,
        ALU_PASSB  = 5'd10,
        ALU_MUL    = 5'd16,
        ALU_MULH   = 5'd17,
        ALU_MULHSU = 5'd18,
        ALU_MULHU  = 5'd19,
        ALU_DIV    = 5'd20,
        ALU_DIVU   = 5'd21,
        ALU_REM    = 5'd22,
        ALU_REMU   = 5'd23
    } alu_op_t;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] DIV_OVF_Q     = 32'h8000_0000;
    localparam logic [31:0] DIV_OVF_R     = 32'h0000_0000;

    // M-extension ops occupy codes 16..23.
    function automatic logic is_muldiv(input logic [4:0] op);
        return (op[4:3] == 2'b10);
    endfunction

endpackage

// File: rtl/execute_stage_muldiv.sv
// ----------------------------------------------------------------------------
// muldiv_unit
// Iterative RV32M multiply/divide. Works on operand magnitudes (shift-add
// multiply, restoring divide) and applies the sign fix-up on the way out.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   i_flush      : abort any operation, return to IDLE
//   i_start      : an M-extension op is present in EX
//   i_op         : operation code (alu_op_t encoding)
//   i_a, i_b     : rs1 and operand B
//   o_stall      : hold upstream (launch cycle and every BUSY cycle)
//   o_done       : o_result is valid this cycle
//   o_result     : final result
// ----------------------------------------------------------------------------
module muldiv_unit
    import riscv_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int MD_CYCLES = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_flush,
    input  logic            i_start,
    input  logic [4:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_stall,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam int         CW     = $clog2(MD_CYCLES) + 1;

    logic [1:0]        r_state;
    logic [CW-1:0]     r_count;
    logic [4:0]        r_op;
    logic [XLEN-1:0]   r_a_orig;
    logic [XLEN-1:0]   r_b_orig;
    logic              r_neg_p;
    logic              r_neg_q;
    logic              r_neg_r;
    logic [2*XLEN-1:0] r_acc;
    logic [2*XLEN-1:0] r_mcand;
    logic [XLEN-1:0]   r_mplier;
    logic [XLEN:0]     r_rem;
    logic [XLEN-1:0]   r_quo;
    logic [XLEN-1:0]   r_divisor;

    // Operand signedness per op
    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;

    always_comb begin
        w_a_signed = 1'b0;
        w_b_signed = 1'b0;
        case (alu_op_t'(i_op))
            ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM: begin
                w_a_signed = 1'b1;
                w_b_signed = 1'b1;
            end
            ALU_MULHSU: w_a_signed = 1'b1;
            default: ;
        endcase
    end

    assign w_a_neg = w_a_signed & i_a[XLEN-1];
    assign w_b_neg = w_b_signed & i_b[XLEN-1];
    assign w_a_mag = w_a_neg ? -i_a : i_a;
    assign w_b_mag = w_b_neg ? -i_b : i_b;

    // One iteration of each algorithm
    logic [2*XLEN-1:0] w_acc_next;
    logic [XLEN:0]     w_rem_shift;
    logic [XLEN:0]     w_diff;
    logic              w_fits;

    assign w_acc_next  = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_rem_shift = {r_rem[XLEN-1:0], r_quo[XLEN-1]};
    assign w_diff      = w_rem_shift - {1'b0, r_divisor};
    assign w_fits      = ~w_diff[XLEN];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_op      <= '0;
            r_a_orig  <= '0;
            r_b_orig  <= '0;
            r_neg_p   <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
        end else if (i_flush) begin
            r_state <= S_IDLE;
            r_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state   <= S_BUSY;
                        r_count   <= '0;
                        r_op      <= i_op;
                        r_a_orig  <= i_a;
                        r_b_orig  <= i_b;
                        r_neg_p   <= w_a_neg ^ w_b_neg;
                        r_neg_q   <= w_a_neg ^ w_b_neg;
                        r_neg_r   <= w_a_neg;
                        r_acc     <= '0;
                        r_mcand   <= {{XLEN{1'b0}}, w_a_mag};
                        r_mplier  <= w_b_mag;
                        r_rem     <= '0;
                        r_quo     <= w_a_mag;
                        r_divisor <= w_b_mag;
                    end
                end
                S_BUSY: begin
                    // Both datapaths advance every cycle; the op picks one at the end.
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_rem    <= w_fits ? w_diff : w_rem_shift;
                    r_quo    <= {r_quo[XLEN-2:0], w_fits};
                    r_count  <= r_count + 1'b1;
                    if (r_count == CW'(MD_CYCLES - 1)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Sign fix-up and corner cases
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_remd;
    logic              w_div_zero;
    logic              w_div_ovf;

    assign w_prod     = r_neg_p ? -r_acc : r_acc;
    assign w_quot     = r_neg_q ? -r_quo : r_quo;
    assign w_remd     = r_neg_r ? -r_rem[XLEN-1:0] : r_rem[XLEN-1:0];
    assign w_div_zero = (r_b_orig == '0);
    assign w_div_ovf  = (r_a_orig == {1'b1, {(XLEN-1){1'b0}}}) && (r_b_orig == '1);

    always_comb begin
        o_result = '0;
        case (alu_op_t'(r_op))
            ALU_MUL:                        o_result = w_prod[XLEN-1:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU: o_result = w_prod[2*XLEN-1:XLEN];
            ALU_DIV, ALU_DIVU: begin
                if (w_div_zero)
                    o_result = DIV_BY_ZERO_Q;
                else if (alu_op_t'(r_op) == ALU_DIV && w_div_ovf)
                    o_result = DIV_OVF_Q;
                else
                    o_result = w_quot;
            end
            ALU_REM, ALU_REMU: begin
                if (w_div_zero)
                    o_result = r_a_orig;
                else if (alu_op_t'(r_op) == ALU_REM && w_div_ovf)
                    o_result = DIV_OVF_R;
                else
                    o_result = w_remd;
            end
            default: ;
        endcase
    end

    assign o_stall = ~i_flush & (((r_state == S_IDLE) & i_start) | (r_state == S_BUSY));
    assign o_done  = (r_state == S_DONE);

endmodule

// File: rtl/execute_stage.sv
// ----------------------------------------------------------------------------
// execute_stage
// EX stage of the RV32IM pipeline: ALU, branch compare, PC+imm, jalr target,
// iterative mul/div, and the EX/MEM pipeline register.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   flush_in              : kill the current EX instruction
//   Ctl_ALUSrc_in         : operand B = Imm_in (1) or ReadData2_in (0)
//   alu_op_in, funct3_in  : operation and branch type
//   Ctl_*_in, jal/jalr_in : control passed through to MEM
//   Rd_in, PC_in, Imm_in, ReadData1_in, ReadData2_in : operands
//   *_out                 : registered EX/MEM fields
//   stall_out             : combinational, hold ID/EX while high
// ----------------------------------------------------------------------------
module execute_stage
    import riscv_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int MD_CYCLES = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush_in,
    input  logic            Ctl_ALUSrc_in,
    input  logic [4:0]      alu_op_in,
    input  logic [2:0]      funct3_in,
    input  logic            Ctl_MemtoReg_in,
    input  logic            Ctl_RegWrite_in,
    input  logic            Ctl_MemRead_in,
    input  logic            Ctl_MemWrite_in,
    input  logic            Ctl_Branch_in,
    input  logic            jal_in,
    input  logic            jalr_in,
    input  logic [4:0]      Rd_in,
    input  logic [XLEN-1:0] PC_in,
    input  logic [XLEN-1:0] Imm_in,
    input  logic [XLEN-1:0] ReadData1_in,
    input  logic [XLEN-1:0] ReadData2_in,
    output logic            Ctl_MemtoReg_out,
    output logic            Ctl_RegWrite_out,
    output logic            Ctl_MemRead_out,
    output logic            Ctl_MemWrite_out,
    output logic            Ctl_Branch_out,
    output logic            jal_out,
    output logic            jalr_out,
    output logic [4:0]      Rd_out,
    output logic            Zero_out,
    output logic [XLEN-1:0] ALUresult_out,
    output logic [XLEN-1:0] Write_Data_out,
    output logic [XLEN-1:0] PCimm_out,
    output logic [XLEN-1:0] PC_out,
    output logic            stall_out
);

    logic [XLEN-1:0] w_b;
    logic [XLEN-1:0] w_alu;
    logic            w_zero;
    logic            w_md_stall;
    logic            w_md_done;
    logic [XLEN-1:0] w_md_result;

    assign w_b = Ctl_ALUSrc_in ? Imm_in : ReadData2_in;

    always_comb begin
        w_alu = '0;
        case (alu_op_t'(alu_op_in))
            ALU_ADD:   w_alu = ReadData1_in + w_b;
            ALU_SUB:   w_alu = ReadData1_in - w_b;
            ALU_SLL:   w_alu = ReadData1_in << w_b[4:0];
            ALU_SLT:   w_alu = XLEN'($signed(ReadData1_in) < $signed(w_b));
            ALU_SLTU:  w_alu = XLEN'(ReadData1_in < w_b);
            ALU_XOR:   w_alu = ReadData1_in ^ w_b;
            ALU_SRL:   w_alu = ReadData1_in >> w_b[4:0];
            ALU_SRA:   w_alu = $unsigned($signed(ReadData1_in) >>> w_b[4:0]);
            ALU_OR:    w_alu = ReadData1_in | w_b;
            ALU_AND:   w_alu = ReadData1_in & w_b;
            ALU_PASSB: w_alu = w_b;
            default: ;
        endcase
        // jalr target is always rs1 + imm with bit 0 cleared, whatever the op.
        if (jalr_in) begin
            w_alu = (ReadData1_in + Imm_in) & ~XLEN'(1);
        end
    end

    // Branch compare uses rs2 even when operand B selects the immediate.
    always_comb begin
        w_zero = 1'b0;
        case (funct3_in)
            F3_BEQ:  w_zero = (ReadData1_in == ReadData2_in);
            F3_BNE:  w_zero = (ReadData1_in != ReadData2_in);
            F3_BLT:  w_zero = ($signed(ReadData1_in) <  $signed(ReadData2_in));
            F3_BGE:  w_zero = ($signed(ReadData1_in) >= $signed(ReadData2_in));
            F3_BLTU: w_zero = (ReadData1_in <  ReadData2_in);
            F3_BGEU: w_zero = (ReadData1_in >= ReadData2_in);
            default: w_zero = 1'b0;
        endcase
    end

    muldiv_unit #(
        .XLEN      (XLEN),
        .MD_CYCLES (MD_CYCLES)
    ) u_muldiv (
        .clk      (clk),
        .reset    (reset),
        .i_flush  (flush_in),
        .i_start  (is_muldiv(alu_op_in)),
        .i_op     (alu_op_in),
        .i_a      (ReadData1_in),
        .i_b      (w_b),
        .o_stall  (w_md_stall),
        .o_done   (w_md_done),
        .o_result (w_md_result)
    );

    assign stall_out = w_md_stall;

    // EX/MEM register
    logic [6:0]      r_ctl;
    logic [4:0]      r_rd;
    logic            r_zero;
    logic [XLEN-1:0] r_alu;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_pcimm;
    logic [XLEN-1:0] r_pc;

    always_ff @(posedge clk) begin
        if (reset || flush_in || w_md_stall) begin
            // bubble: nothing reaches MEM
            r_ctl   <= '0;
            r_rd    <= '0;
            r_zero  <= 1'b0;
            r_alu   <= '0;
            r_wdata <= '0;
            r_pcimm <= '0;
            r_pc    <= '0;
        end else begin
            r_ctl   <= {Ctl_MemtoReg_in, Ctl_RegWrite_in, Ctl_MemRead_in,
                        Ctl_MemWrite_in, Ctl_Branch_in, jal_in, jalr_in};
            r_rd    <= Rd_in;
            r_zero  <= w_zero;
            r_alu   <= w_md_done ? w_md_result : w_alu;
            r_wdata <= ReadData2_in;
            r_pcimm <= PC_in + Imm_in;
            r_pc    <= PC_in;
        end
    end

    assign {Ctl_MemtoReg_out, Ctl_RegWrite_out, Ctl_MemRead_out,
            Ctl_MemWrite_out, Ctl_Branch_out, jal_out, jalr_out} = r_ctl;
    assign Rd_out         = r_rd;
    assign Zero_out       = r_zero;
    assign ALUresult_out  = r_alu;
    assign Write_Data_out = r_wdata;
    assign PCimm_out      = r_pcimm;
    assign PC_out         = r_pc;

endmodule

// File: tb/tb_execute_stage.sv
// ----------------------------------------------------------------------------
// tb_execute_stage
// Scoreboard bench for execute_stage: every transaction pushes its expected
// EX/MEM contents when driven; they are popped and compared when the stage
// writes them. Bubbles during mul/div stalls and flush/reset are also checked.
// ----------------------------------------------------------------------------
module tb_execute_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset, flush_in, Ctl_ALUSrc_in;
    logic [4:0]  alu_op_in;
    logic [2:0]  funct3_in;
    logic        Ctl_MemtoReg_in, Ctl_RegWrite_in, Ctl_MemRead_in, Ctl_MemWrite_in;
    logic        Ctl_Branch_in, jal_in, jalr_in;
    logic [4:0]  Rd_in;
    logic [31:0] PC_in, Imm_in, ReadData1_in, ReadData2_in;
    logic        Ctl_MemtoReg_out, Ctl_RegWrite_out, Ctl_MemRead_out, Ctl_MemWrite_out;
    logic        Ctl_Branch_out, jal_out, jalr_out;
    logic [4:0]  Rd_out;
    logic        Zero_out;
    logic [31:0] ALUresult_out, Write_Data_out, PCimm_out, PC_out;
    logic        stall_out;

    always #5 clk = ~clk;

    execute_stage #(.XLEN(32), .MD_CYCLES(32)) dut (
        .clk(clk), .reset(reset), .flush_in(flush_in), .Ctl_ALUSrc_in(Ctl_ALUSrc_in),
        .alu_op_in(alu_op_in), .funct3_in(funct3_in),
        .Ctl_MemtoReg_in(Ctl_MemtoReg_in), .Ctl_RegWrite_in(Ctl_RegWrite_in),
        .Ctl_MemRead_in(Ctl_MemRead_in), .Ctl_MemWrite_in(Ctl_MemWrite_in),
        .Ctl_Branch_in(Ctl_Branch_in), .jal_in(jal_in), .jalr_in(jalr_in),
        .Rd_in(Rd_in), .PC_in(PC_in), .Imm_in(Imm_in),
        .ReadData1_in(ReadData1_in), .ReadData2_in(ReadData2_in),
        .Ctl_MemtoReg_out(Ctl_MemtoReg_out), .Ctl_RegWrite_out(Ctl_RegWrite_out),
        .Ctl_MemRead_out(Ctl_MemRead_out), .Ctl_MemWrite_out(Ctl_MemWrite_out),
        .Ctl_Branch_out(Ctl_Branch_out), .jal_out(jal_out), .jalr_out(jalr_out),
        .Rd_out(Rd_out), .Zero_out(Zero_out), .ALUresult_out(ALUresult_out),
        .Write_Data_out(Write_Data_out), .PCimm_out(PCimm_out), .PC_out(PC_out),
        .stall_out(stall_out)
    );

    logic [6:0] ctl_out;
    assign ctl_out = {Ctl_MemtoReg_out, Ctl_RegWrite_out, Ctl_MemRead_out,
                      Ctl_MemWrite_out, Ctl_Branch_out, jal_out, jalr_out};

    // ctl order: {MemtoReg, RegWrite, MemRead, MemWrite, Branch, jal, jalr}
    typedef struct {
        logic [4:0]  op;
        logic        alusrc;
        logic [2:0]  f3;
        logic [6:0]  ctl;
        logic [4:0]  rd;
        logic [31:0] pc, imm, rs1, rs2;
    } txn_t;

    typedef struct {
        logic [31:0] alu, pcimm, pc, wd;
        logic        zero;
        logic [4:0]  rd;
        logic [6:0]  ctl;
        int          stalls;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic txn_t mk(input logic [4:0] op, input logic alusrc, input logic [2:0] f3,
                                input logic [6:0] ctl, input logic [4:0] rd, input logic [31:0] pc,
                                input logic [31:0] imm, input logic [31:0] rs1, input logic [31:0] rs2);
        txn_t t;
        t.op = op; t.alusrc = alusrc; t.f3 = f3; t.ctl = ctl; t.rd = rd;
        t.pc = pc; t.imm = imm; t.rs1 = rs1; t.rs2 = rs2;
        return t;
    endfunction

    // Reference model using native arithmetic
    function automatic exp_t model(input txn_t t);
        exp_t e;
        logic [31:0] a, b, r;
        logic [63:0] sa, sbx, za, zb, p;
        a = t.rs1;
        b = t.alusrc ? t.imm : t.rs2;
        sa = {{32{a[31]}}, a}; sbx = {{32{b[31]}}, b};
        za = {32'b0, a};       zb = {32'b0, b};
        r = 32'b0;
        e.stalls = 0;
        case (t.op)
            ALU_ADD:    r = a + b;
            ALU_SUB:    r = a - b;
            ALU_SLL:    r = a << b[4:0];
            ALU_SLT:    r = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU:   r = {31'b0, a < b};
            ALU_XOR:    r = a ^ b;
            ALU_SRL:    r = a >> b[4:0];
            ALU_SRA:    r = $signed(a) >>> b[4:0];
            ALU_OR:     r = a | b;
            ALU_AND:    r = a & b;
            ALU_PASSB:  r = b;
            ALU_MUL:    begin p = sa * sbx; r = p[31:0];  end
            ALU_MULH:   begin p = sa * sbx; r = p[63:32]; end
            ALU_MULHSU: begin p = sa * zb;  r = p[63:32]; end
            ALU_MULHU:  begin p = za * zb;  r = p[63:32]; end
            ALU_DIV:    if (b == 0) r = 32'hFFFFFFFF;
                        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h80000000;
                        else r = $signed(a) / $signed(b);
            ALU_DIVU:   r = (b == 0) ? 32'hFFFFFFFF : a / b;
            ALU_REM:    if (b == 0) r = a;
                        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 0;
                        else r = $signed(a) % $signed(b);
            ALU_REMU:   r = (b == 0) ? a : a % b;
            default:    r = 32'b0;
        endcase
        if (t.op[4:3] == 2'b10) e.stalls = 33;
        if (t.ctl[0]) r = (t.rs1 + t.imm) & 32'hFFFFFFFE;
        case (t.f3)
            3'b000:  e.zero = (t.rs1 == t.rs2);
            3'b001:  e.zero = (t.rs1 != t.rs2);
            3'b100:  e.zero = ($signed(t.rs1) < $signed(t.rs2));
            3'b101:  e.zero = ($signed(t.rs1) >= $signed(t.rs2));
            3'b110:  e.zero = (t.rs1 < t.rs2);
            3'b111:  e.zero = (t.rs1 >= t.rs2);
            default: e.zero = 1'b0;
        endcase
        e.alu = r; e.pcimm = t.pc + t.imm; e.pc = t.pc; e.wd = t.rs2;
        e.rd = t.rd; e.ctl = t.ctl;
        return e;
    endfunction

    task automatic drive(input txn_t t);
        alu_op_in = t.op; Ctl_ALUSrc_in = t.alusrc; funct3_in = t.f3;
        {Ctl_MemtoReg_in, Ctl_RegWrite_in, Ctl_MemRead_in, Ctl_MemWrite_in,
         Ctl_Branch_in, jal_in, jalr_in} = t.ctl;
        Rd_in = t.rd; PC_in = t.pc; Imm_in = t.imm;
        ReadData1_in = t.rs1; ReadData2_in = t.rs2;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_ctl"},   {57'b0, ctl_out}, 64'd0);
        check_val({tag, "_rdz"},   {58'b0, Rd_out, Zero_out}, 64'd0);
        check_val({tag, "_alu"},   {32'b0, ALUresult_out}, 64'd0);
        check_val({tag, "_wd"},    {32'b0, Write_Data_out}, 64'd0);
        check_val({tag, "_pcimm"}, {32'b0, PCimm_out}, 64'd0);
        check_val({tag, "_pc"},    {32'b0, PC_out}, 64'd0);
    endtask

    // Called ~1 time unit after a rising edge.
    task automatic run_txn(input string name, input txn_t t);
        exp_t e;
        int   stalls;
        drive(t);
        sb.push_back(model(t));
        #1;
        stalls = 0;
        while (stall_out && stalls < 100) begin
            stalls++;
            @(posedge clk); #1;
            check_val({name, "_bubble"}, {25'b0, ctl_out, ALUresult_out}, 64'd0);
        end
        if (stalls >= 100) check_val({name, "_timeout"}, 64'd1, 64'd0);
        @(posedge clk); #1;
        e = sb.pop_front();
        check_val({name, "_stalls"}, 64'(stalls), 64'(e.stalls));
        check_val({name, "_alu"},    {32'b0, ALUresult_out}, {32'b0, e.alu});
        check_val({name, "_zero"},   {63'b0, Zero_out}, {63'b0, e.zero});
        check_val({name, "_pcimm"},  {32'b0, PCimm_out}, {32'b0, e.pcimm});
        check_val({name, "_pc_wd"},  {PC_out, Write_Data_out}, {e.pc, e.wd});
        check_val({name, "_rd_ctl"}, {52'b0, Rd_out, ctl_out}, {52'b0, e.rd, e.ctl});
        $display("TXN %-8s alu=%h zero=%0d pcimm=%h rd=%0d ctl=%b stalls=%0d",
                 name, ALUresult_out, Zero_out, PCimm_out, Rd_out, ctl_out, stalls);
    endtask

    txn_t idle_t;

    initial begin
        idle_t = mk(ALU_ADD, 0, 3'b010, 7'b0, 0, 0, 0, 0, 0);
        drive(idle_t);
        flush_in = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        check_val("reset_stall", {63'b0, stall_out}, 64'd0);
        reset = 1'b0;

        run_txn("ADD",    mk(ALU_ADD, 1, 3'b010, 7'b0100000, 7, 0, 32'hFFFFFFFD, 5, 0));
        run_txn("BLT",    mk(ALU_SUB, 0, 3'b100, 7'b0000100, 0, 32'h40, 32'h10, 32'hFFFFFFFF, 1));
        run_txn("BLTU",   mk(ALU_SUB, 0, 3'b110, 7'b0000100, 0, 32'h40, 32'h10, 32'hFFFFFFFF, 1));
        run_txn("BGEU",   mk(ALU_SUB, 1, 3'b111, 7'b0000100, 0, 32'h80, 32'h7, 5, 5));
        run_txn("BNE",    mk(ALU_SUB, 0, 3'b001, 7'b0000100, 0, 32'h84, 32'hFFFFFFF8, 5, 5));
        run_txn("SRA",    mk(ALU_SRA, 0, 3'b010, 7'b0100000, 3, 4, 0, 32'h80000000, 36));
        run_txn("SLT",    mk(ALU_SLT, 1, 3'b011, 7'b0100000, 4, 8, 32'hFFFFFFFF, 32'hFFFFFFFE, 9));
        run_txn("SW",     mk(ALU_ADD, 1, 3'b010, 7'b0001000, 0, 12, 8, 32'h1000, 32'hDEADBEEF));
        run_txn("PASSB",  mk(ALU_PASSB, 1, 3'b010, 7'b0100000, 9, 16, 32'h12345000, 0, 0));
        run_txn("JALR",   mk(ALU_ADD, 1, 3'b000, 7'b0100001, 1, 32'h200, 4, 32'h103, 0));
        run_txn("MUL",    mk(ALU_MUL, 0, 3'b010, 7'b0100000, 10, 0, 0, 7, 32'hFFFFFFFA));
        run_txn("MULHU",  mk(ALU_MULHU, 0, 3'b010, 7'b0100000, 11, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF));
        run_txn("MULH",   mk(ALU_MULH, 0, 3'b010, 7'b0100000, 12, 0, 0, 32'hFFFFFFFE, 3));
        run_txn("MULHSU", mk(ALU_MULHSU, 0, 3'b010, 7'b0100000, 13, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF));
        run_txn("DIVOVF", mk(ALU_DIV, 0, 3'b010, 7'b0100000, 14, 0, 0, 32'h80000000, 32'hFFFFFFFF));
        run_txn("REM0",   mk(ALU_REM, 0, 3'b010, 7'b0100000, 15, 0, 0, 17, 0));
        run_txn("DIVU",   mk(ALU_DIVU, 0, 3'b010, 7'b0100000, 16, 0, 0, 100, 7));
        run_txn("REMU",   mk(ALU_REMU, 0, 3'b010, 7'b0100000, 17, 0, 0, 100, 7));
        run_txn("DIVNEG", mk(ALU_DIV, 0, 3'b010, 7'b0100000, 18, 0, 0, 32'hFFFFFFF9, 2));
        run_txn("REMNEG", mk(ALU_REM, 0, 3'b010, 7'b0100000, 19, 0, 0, 32'hFFFFFFF9, 2));
        run_txn("DIVU0",  mk(ALU_DIVU, 0, 3'b010, 7'b0100000, 20, 0, 0, 55, 0));

        // Flush in the 10th BUSY cycle of a divide
        drive(mk(ALU_DIV, 0, 3'b010, 7'b0100000, 21, 0, 0, 100, 7));
        #1;
        check_val("flush_pre_stall", {63'b0, stall_out}, 64'd1);
        repeat (10) @(posedge clk);
        #1;
        flush_in = 1'b1;
        #1;
        check_val("flush_stall", {63'b0, stall_out}, 64'd0);
        @(posedge clk); #1;
        check_val("flush_bubble", {25'b0, ctl_out, ALUresult_out}, 64'd0);
        flush_in = 1'b0;
        run_txn("ADDPF",  mk(ALU_ADD, 0, 3'b010, 7'b0100000, 22, 0, 0, 40, 2));

        // Reset in the middle of a multiply
        drive(mk(ALU_MUL, 0, 3'b010, 7'b0100000, 23, 32'h44, 0, 3, 4));
        repeat (6) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        drive(idle_t);
        #1;
        check_all_zero("midrst");
        check_val("midrst_stall", {63'b0, stall_out}, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        run_txn("ADDPR",  mk(ALU_XOR, 0, 3'b010, 7'b0100000, 24, 32'h48, 0, 32'hF0F0F0F0, 32'h0FF00FF0));

        if (sb.size() != 0) check_val("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
